// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// opcode/funct constants and ALU-op encodings.
// Build option: define ITYPE_ALU_EN to add the I-type ALU states IEXEC/IWB.
package mc_ctrl_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
`ifdef ITYPE_ALU_EN
    ,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
`endif
  } state_t;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct codes (instruction bits [5:0]); also used as alu_fun values
  localparam logic [5:0] FN_NONE  = 6'b000000;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // ALU-op encodings {aluop1, aluop0}
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b01;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMMSL2 = 2'b11;

  // True for the immediate-ALU opcodes handled by IEXEC/IWB
  function automatic logic is_itype_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/mc_control_ifunct_map.sv
// Combinational I-type opcode to ALU function translation.
// Unknown opcodes map to 000000 so the ALU sees a benign function.
module ifunct_map
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output logic [5:0] o_alu_fun
);

  // Pick the R-type funct code equivalent to each immediate instruction
  always_comb begin
    o_alu_fun = FN_NONE;
    case (i_opcode)
      OP_ADDI: o_alu_fun = FN_ADD;
      OP_ANDI: o_alu_fun = FN_AND;
      OP_ORI:  o_alu_fun = FN_OR;
      OP_SLTI: o_alu_fun = FN_SLT;
      default: o_alu_fun = FN_NONE;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle datapath control FSM (Moore style).
// Build option: ITYPE_ALU_EN adds the IEXEC/IWB path for addi/andi/ori/slti;
// without it those opcodes are reported as illegal in DECODE.
module mc_control
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] pc_source,
  output logic [1:0] alu_src_b,
  output logic       aluop1,
  output logic       aluop0,
  output logic [5:0] alu_fun,
  output logic       instr_done,
  output logic       illegal_op
);

  logic [STATE_W-1:0] r_state;
  logic               r_is_store;
  state_t             w_state;
  state_t             w_next;

  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_instr_done;
  logic       w_illegal_op;
  logic [1:0] w_aluop;

  assign w_state = state_t'(r_state[STATE_BITS-1:0]);

`ifdef ITYPE_ALU_EN
  logic [5:0] w_ifun;

  ifunct_map u_ifunct_map (
    .i_opcode  (opcode),
    .o_alu_fun (w_ifun)
  );
`endif

  // State register; reset forces FETCH immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= STATE_W'(S_FETCH);
    else       r_state <= STATE_W'(w_next);
  end

  // Remember lw vs sw at DECODE so MEMADR never looks at the opcode bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_is_store <= 1'b0;
    else if (w_state == S_DECODE) r_is_store <= (opcode == OP_SW);
  end

  // Next-state selection and per-state control outputs
  always_comb begin
    w_next          = w_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    iord            = 1'b0;
    mem_read        = 1'b0;
    w_mem_write     = 1'b0;
    mem_to_reg      = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    reg_dst         = 1'b0;
    alu_src_a       = 1'b0;
    pc_source       = PCSRC_ALU;
    alu_src_b       = ALUB_REG;
    w_aluop         = ALUOP_MEM;
    alu_fun         = FN_NONE;
    w_instr_done    = 1'b0;
    w_illegal_op    = 1'b0;
    case (w_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        w_ir_write = 1'b1;
        alu_src_b  = ALUB_FOUR;
        w_pc_write = 1'b1;
        pc_source  = PCSRC_ALU;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = ALUB_IMMSL2;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_REXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
`ifdef ITYPE_ALU_EN
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_IEXEC;
`endif
          default: begin
            w_next       = S_FETCH;
            w_illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        w_next    = r_is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        w_next   = S_MEMWB;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        mem_to_reg   = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_write  = 1'b1;
        iord         = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_REG;
        w_aluop   = ALUOP_RTYPE;
        alu_fun   = funct;
        w_next    = S_RWB;
      end
      S_RWB: begin
        w_reg_write  = 1'b1;
        reg_dst      = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
`ifdef ITYPE_ALU_EN
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        w_aluop   = ALUOP_ITYPE;
        alu_fun   = w_ifun;
        w_next    = S_IWB;
      end
      S_IWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
`endif
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_src_b       = ALUB_REG;
        w_aluop         = ALUOP_ITYPE;
        alu_fun         = FN_SUB;
        w_pc_write_cond = 1'b1;
        pc_source       = PCSRC_ALUOUT;
        w_instr_done    = 1'b1;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write   = 1'b1;
        pc_source    = PCSRC_JUMP;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write enables and status pulses are held off for as long as reset is high
  assign pc_write      = w_pc_write      & ~reset;
  assign pc_write_cond = w_pc_write_cond & ~reset;
  assign mem_write     = w_mem_write     & ~reset;
  assign ir_write      = w_ir_write      & ~reset;
  assign reg_write     = w_reg_write     & ~reset;
  assign instr_done    = w_instr_done    & ~reset;
  assign illegal_op    = w_illegal_op    & ~reset;
  assign aluop1        = w_aluop[1];
  assign aluop0        = w_aluop[0];

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control. Expected control vectors come from a
// per-state table written from the behavioural description, queued as each
// cycle is stimulated and compared at the following falling edge.
module tb_mc_control;

  localparam int S_FETCH  = 0;
  localparam int S_DECODE = 1;
  localparam int S_MEMADR = 2;
  localparam int S_MEMRD  = 3;
  localparam int S_MEMWB  = 4;
  localparam int S_MEMWR  = 5;
  localparam int S_REXEC  = 6;
  localparam int S_RWB    = 7;
  localparam int S_IEXEC  = 8;
  localparam int S_IWB    = 9;
  localparam int S_BRANCH = 10;
  localparam int S_JUMP   = 11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic       aluop1;
    logic       aluop0;
    logic [5:0] alu_fun;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  typedef struct {
    string tag;
    ctrl_t exp;
    ctrl_t mask;
  } sb_entry_t;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  ctrl_t      obs;

  sb_entry_t  sbq[$];
  int         assertCount;
  int         failCount;
  ctrl_t      maskAll;
  ctrl_t      maskEn;

  mc_control #(.STATE_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .pc_write      (obs.pc_write),
    .pc_write_cond (obs.pc_write_cond),
    .iord          (obs.iord),
    .mem_read      (obs.mem_read),
    .mem_write     (obs.mem_write),
    .mem_to_reg    (obs.mem_to_reg),
    .ir_write      (obs.ir_write),
    .reg_write     (obs.reg_write),
    .reg_dst       (obs.reg_dst),
    .alu_src_a     (obs.alu_src_a),
    .pc_source     (obs.pc_source),
    .alu_src_b     (obs.alu_src_b),
    .aluop1        (obs.aluop1),
    .aluop0        (obs.aluop0),
    .alu_fun       (obs.alu_fun),
    .instr_done    (obs.instr_done),
    .illegal_op    (obs.illegal_op)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Opcodes the control unit accepts in this build
  function automatic bit isLegal(input logic [5:0] op);
    bit legal;
    legal = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
            (op == 6'b000100) || (op == 6'b000010);
`ifdef ITYPE_ALU_EN
    legal = legal || (op == 6'b001000) || (op == 6'b001100) ||
            (op == 6'b001101) || (op == 6'b001010);
`endif
    return legal;
  endfunction

  // Reference control vector for one state
  function automatic ctrl_t model(input int s, input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1; c.ir_write = 1; c.alu_src_b = 2'b01; c.pc_write = 1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.illegal_op = !isLegal(op);
      end
      S_MEMADR: begin
        c.alu_src_a = 1; c.alu_src_b = 2'b10;
      end
      S_MEMRD:  begin c.mem_read = 1; c.iord = 1; end
      S_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
      S_MEMWR:  begin c.mem_write = 1; c.iord = 1; c.instr_done = 1; end
      S_REXEC: begin
        c.alu_src_a = 1; c.aluop1 = 1; c.alu_fun = fn;
      end
      S_RWB:    begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
      S_IEXEC: begin
        c.alu_src_a = 1; c.alu_src_b = 2'b10; c.aluop0 = 1;
        case (op)
          6'b001000: c.alu_fun = 6'b100000;
          6'b001100: c.alu_fun = 6'b100100;
          6'b001101: c.alu_fun = 6'b100101;
          6'b001010: c.alu_fun = 6'b101010;
          default:   c.alu_fun = 6'b000000;
        endcase
      end
      S_IWB:    begin c.reg_write = 1; c.instr_done = 1; end
      S_BRANCH: begin
        c.alu_src_a = 1; c.aluop0 = 1; c.alu_fun = 6'b100010;
        c.pc_write_cond = 1; c.pc_source = 2'b01; c.instr_done = 1;
      end
      S_JUMP:   begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Drive the inputs for one cycle and queue the expected response.
  // Opcode/funct carry the real instruction only where the FSM is allowed
  // to look at them; elsewhere they are scrambled.
  task automatic applyStimulus(input int s, input logic [5:0] op, input logic [5:0] fn,
                               input string tag, input ctrl_t mask);
    sb_entry_t e;
    if (s == S_DECODE || s == S_REXEC || s == S_IEXEC) begin
      opcode = op;
      funct  = fn;
    end else begin
      opcode = 6'($urandom);
      funct  = 6'($urandom);
    end
    e.tag  = tag;
    e.exp  = (reset === 1'b1) ? ctrl_t'('0) : model(s, op, fn);
    e.mask = mask;
    sbq.push_back(e);
  endtask

  // Pop the oldest expectation and compare against the outputs
  task automatic checkOutput();
    sb_entry_t e;
    if (sbq.size() == 0) begin
      assertCount++;
      failCount++;
      $error("[TB] FAIL scoreboard_empty observed=%0d expected=1", sbq.size());
    end else begin
      e = sbq.pop_front();
      assertCount++;
      assert ((obs & e.mask) === (e.exp & e.mask)) else begin
        failCount++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs & e.mask, e.exp & e.mask);
      end
    end
  endtask

  // One clocked step: stimulate after the rising edge, check at the falling edge
  task automatic stepState(input int s, input logic [5:0] op, input logic [5:0] fn, input string tag);
    applyStimulus(s, op, fn, tag, maskAll);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // Run one whole instruction through its expected state sequence
  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input string name);
    int seq[$];
    seq = '{S_FETCH, S_DECODE};
    if (!isLegal(op))                          seq = seq;
    else if (op == 6'b100011)                  seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
    else if (op == 6'b101011)                  seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
    else if (op == 6'b000000)                  seq = '{S_FETCH, S_DECODE, S_REXEC, S_RWB};
    else if (op == 6'b000100)                  seq = '{S_FETCH, S_DECODE, S_BRANCH};
    else if (op == 6'b000010)                  seq = '{S_FETCH, S_DECODE, S_JUMP};
    else                                       seq = '{S_FETCH, S_DECODE, S_IEXEC, S_IWB};
    foreach (seq[i]) stepState(seq[i], op, fn, $sformatf("%s_c%0d", name, i + 1));
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    maskAll     = '1;
    maskEn      = '0;
    maskEn.pc_write      = 1'b1;
    maskEn.pc_write_cond = 1'b1;
    maskEn.ir_write      = 1'b1;
    maskEn.mem_write     = 1'b1;
    maskEn.reg_write     = 1'b1;
    maskEn.instr_done    = 1'b1;
    maskEn.illegal_op    = 1'b1;
    reset  = 1'b1;
    opcode = 6'b000000;
    funct  = 6'b000000;

    // Reset held for three cycles: every write enable must stay low
    for (int i = 0; i < 3; i++) begin
      applyStimulus(S_FETCH, 6'd0, 6'd0, $sformatf("reset_hold_%0d", i), maskEn);
      @(negedge clk);
      checkOutput();
      @(posedge clk);
    end
    #1;
    reset = 1'b0;

    // Normal instruction mix
    runInstr(6'b100011, 6'b000000, "lw");
    runInstr(6'b101011, 6'b000000, "sw");
    runInstr(6'b000000, 6'b101010, "r_slt");
    runInstr(6'b000000, 6'b100000, "r_add");
    runInstr(6'b001101, 6'b000000, "ori");
    runInstr(6'b001000, 6'b000000, "addi");
    runInstr(6'b000100, 6'b000000, "beq");
    runInstr(6'b000010, 6'b000000, "j");
    runInstr(6'b111111, 6'b000000, "illegal");
    runInstr(6'b100011, 6'b000000, "lw2");

    // sw interrupted by reset while in MEMWR
    stepState(S_FETCH,  6'b101011, 6'd0, "swrst_fetch");
    stepState(S_DECODE, 6'b101011, 6'd0, "swrst_decode");
    stepState(S_MEMADR, 6'b101011, 6'd0, "swrst_memadr");
    applyStimulus(S_MEMWR, 6'b101011, 6'd0, "swrst_memwr", maskAll);
    #2;
    checkOutput();
    reset = 1'b1;
    #1;
    applyStimulus(S_FETCH, 6'd0, 6'd0, "swrst_in_reset", maskEn);
    checkOutput();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fresh instructions after the aborted store
    runInstr(6'b000010, 6'b000000, "j_after_rst");
    runInstr(6'b000000, 6'b100100, "r_and");

    if (sbq.size() != 0) begin
      assertCount++;
      failCount++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: STATE_W, default 4, width of the state register (the twelve states of REQ-010 need at least 4 bits).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26], taken from the instruction register.
REQ-005 funct  input  6  instruction bits [5:0], taken from the instruction register.
REQ-006 Datapath-control outputs, 1 bit each: pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a.
REQ-007 Datapath-control outputs: pc_source (2 bits: 00 ALU, 01 ALUOut, 10 jump target); alu_src_b (2 bits: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2).
REQ-008 aluop1, aluop0 (1 bit each) and alu_fun (6 bits) are outputs that drive the downstream ALU-control stage.
REQ-009 Status outputs, 1 bit each: instr_done (one-cycle pulse when an instruction completes) and illegal_op (one-cycle pulse on an unsupported opcode).

Function
REQ-010 The block SHALL be a Moore FSM with these states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BRANCH, JUMP.
REQ-011 FETCH: mem_read=1, ir_write=1, alu_src_b=01, aluop=00, pc_write=1, pc_source=00; next state is DECODE.
REQ-012 DECODE: alu_src_b=11, aluop=00; next state by opcode:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 -> REXEC
- 000100 (beq) -> BRANCH
- 000010 (j) -> JUMP
- 001000, 001100, 001101, 001010 (addi, andi, ori, slti) -> IEXEC
- any other opcode -> FETCH, with illegal_op=1 for that DECODE cycle.
REQ-013 MEMADR: alu_src_a=1, alu_src_b=10, aluop=00; next state MEMRD for lw, MEMWR for sw.
REQ-014 MEMRD: mem_read=1, iord=1; next state MEMWB.
REQ-015 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; next state FETCH.
REQ-016 MEMWR: mem_write=1, iord=1, instr_done=1; next state FETCH.
REQ-017 REXEC: alu_src_a=1, alu_src_b=00, aluop=10, alu_fun=funct; next state RWB.
REQ-018 RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; next state FETCH.
REQ-019 IEXEC: alu_src_a=1, alu_src_b=10, aluop=01; alu_fun by opcode: addi 100000, andi 100100, ori 100101, slti 101010. Next state IWB.
REQ-020 IWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; next state FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, aluop=01, alu_fun=100010 (sub), pc_write_cond=1, pc_source=01, instr_done=1; next state FETCH.
REQ-022 JUMP: pc_write=1, pc_source=10, instr_done=1; next state FETCH.
REQ-023 Every output not listed for a state SHALL be 0; alu_fun SHALL be 000000 outside REXEC, IEXEC and BRANCH.
REQ-024 Cycles per instruction, FETCH to the instr_done cycle inclusive: lw 5; sw, R-type and I-type 4; beq and j 3; an illegal opcode takes 2 cycles with no instr_done.
REQ-025 opcode and funct are sampled only in DECODE, REXEC and IEXEC; changes in any other state SHALL have no effect.

Reset
REQ-026 Asserting reset SHALL set the state to FETCH immediately (asynchronously).
REQ-027 While reset is high, pc_write, pc_write_cond, ir_write, mem_write, reg_write, instr_done and illegal_op SHALL be 0.
REQ-028 Reset asserted mid-instruction SHALL abort that instruction with no further write enables; the first FETCH actions occur in the first clk edge after reset deasserts.

Configuration
REQ-029 Macro ITYPE_ALU_EN:
- Defined: IEXEC and IWB exist and REQ-019/REQ-020 apply.
- Undefined: those two states are absent, and opcodes 001000/001100/001101/001010 are treated as illegal per REQ-012.

Structure
REQ-030 Package mc_ctrl_pkg SHALL hold:
- the state enum;
- opcode constants;
- funct constants (add, sub, and, or, slt, sll);
- aluop encodings: 00 mem/address, 10 R-type, 01 I-type/branch.
REQ-031 The I-type opcode to alu_fun mapping SHALL be a separate combinational sub-module, ifunct_map.

Verification
REQ-032 Reset held 3 cycles, then released -> all write enables 0 during reset; FETCH on the first edge with pc_write=1, ir_write=1, mem_read=1.
REQ-033 lw (100011) -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 only in cycle 5; instr_done pulses once.
REQ-034 R-type with funct=101010 -> REXEC drives aluop=10, alu_fun=101010; RWB drives reg_dst=1, reg_write=1.
REQ-035 ori (001101) -> IEXEC drives aluop=01, alu_fun=100101; with ITYPE_ALU_EN undefined -> illegal_op=1 in DECODE, then FETCH.
REQ-036 beq then j back-to-back -> 3 cycles each; BRANCH drives pc_write_cond=1, alu_fun=100010; JUMP drives pc_source=10.
REQ-037 Reset asserted during MEMWR -> mem_write drops the same cycle; state is FETCH after release.
